bus_capture_sequencer: RTL

Programmable sequencer for the serial bus analyser's capture datapath. A small, run-time-writable state table walks the analyser through protocol fields. Each table entry gives the field length in bits, the next state and an end-of-frame flag. The block shifts incoming sample bits into a field register and emits each completed field on a ready/valid port, tagged with its state index. It sits between the bus sampler (bit stream in) and the decode/trace buffer (field words out).

---
 rtl/bus_capture_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_capture_sequencer.sv
// Table-driven capture sequencer: walks a run-time-writable state table, shifts
// sample bits into fields and emits each completed field on a ready/valid port.
module bus_capture_sequencer #(
  parameter int unsigned NSTATE  = 8,
  parameter int unsigned SW      = $clog2(NSTATE),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_addr,
  input  logic [SW-1:0] cfg_next,
  input  logic [5:0]    cfg_len,
  input  logic          cfg_last,
  input  logic          start,
  input  logic [SW-1:0] start_state,
  input  logic          abort,
  input  logic          smp_valid,
  input  logic          smp_bit,
  output logic          fld_valid,
  input  logic          fld_ready,
  output logic [31:0]   fld_data,
  output logic [SW-1:0] fld_state,
  output logic [5:0]    fld_len,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overrun
);

  localparam int unsigned   IW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT - 1);
  localparam logic [5:0]    MAX_LEN  = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    EMIT,
    DONE
  } state_e;

  state_e        state_q;
  logic [SW-1:0] cur_q;
  logic [5:0]    len_q;
  logic [SW-1:0] next_q;
  logic          last_q;
  logic [5:0]    bit_cnt_q;
  logic [31:0]   shift_q;
  logic [IW-1:0] idle_cnt_q;

  logic          fld_valid_q;
  logic [31:0]   fld_data_q;
  logic [SW-1:0] fld_state_q;
  logic [5:0]    fld_len_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic [SW-1:0] tbl_next_q [NSTATE];
  logic [5:0]    tbl_len_q  [NSTATE];
  logic          tbl_last_q [NSTATE];

  logic [5:0]    ent_len_d;
  logic [5:0]    bit_cnt_d;
  logic [31:0]   shift_d;
  logic          drop_d;

  always_comb begin
    ent_len_d = tbl_len_q[cur_q];
    if (ent_len_d > MAX_LEN) begin
      ent_len_d = MAX_LEN;
    end
    bit_cnt_d = bit_cnt_q + 6'd1;
    shift_d   = {shift_q[30:0], smp_bit};
    drop_d    = smp_valid && ((state_q == LOAD) || (state_q == EMIT) || (state_q == DONE));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      len_q        <= '0;
      next_q       <= '0;
      last_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      fld_valid_q  <= 1'b0;
      fld_data_q   <= '0;
      fld_state_q  <= '0;
      fld_len_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned i = 0; i < NSTATE; i++) begin
        tbl_next_q[SW'(i)] <= '0;
        tbl_len_q[SW'(i)]  <= '0;
        tbl_last_q[SW'(i)] <= 1'b1;
      end
    end else begin
      frame_done_q <= 1'b0;
      if (drop_d) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (cfg_we) begin
            tbl_next_q[cfg_addr] <= cfg_next;
            tbl_len_q[cfg_addr]  <= cfg_len;
            tbl_last_q[cfg_addr] <= cfg_last;
          end
          if (start) begin
            cur_q       <= start_state;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end

        LOAD: begin
          len_q      <= ent_len_d;
          next_q     <= tbl_next_q[cur_q];
          last_q     <= tbl_last_q[cur_q];
          bit_cnt_q  <= '0;
          shift_q    <= '0;
          idle_cnt_q <= '0;
          if (abort) begin
            frame_err_q  <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (ent_len_d == 6'd0) begin
            // Zero-length entries produce no field: finish or chain straight on.
            if (tbl_last_q[cur_q]) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              cur_q   <= tbl_next_q[cur_q];
              state_q <= LOAD;
            end
          end else begin
            state_q <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (abort) begin
            frame_err_q  <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (smp_valid) begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= '0;
            if (bit_cnt_d == len_q) begin
              fld_valid_q <= 1'b1;
              fld_data_q  <= shift_d;
              fld_state_q <= cur_q;
              fld_len_q   <= len_q;
              state_q     <= EMIT;
            end
          end else if (idle_cnt_q == IDLE_LIM) begin
            // Counter would reach TIMEOUT on this edge: abort the frame now.
            frame_err_q  <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end

        EMIT: begin
          if (abort) begin
            fld_valid_q  <= 1'b0;
            frame_err_q  <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (fld_ready) begin
            fld_valid_q <= 1'b0;
            if (last_q) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              cur_q   <= next_q;
              state_q <= LOAD;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q      <= 1'b0;
          fld_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign fld_valid  = fld_valid_q;
  assign fld_data   = fld_data_q;
  assign fld_state  = fld_state_q;
  assign fld_len    = fld_len_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
